// File: rtl/mult_nibble_sequencer_if.sv
// Bus interface for mult_nibble_sequencer.
//   start/a_in/b_in : multiply request and operands (from requester)
//   ready/busy/done : handshake and status (from sequencer)
//   a_nib/b_nib     : nibble pair for the current step (to 4x4 partial-product path)
//   state           : 2-bit shift code for the alignment stage
//   pp_in           : aligned partial product returned combinationally
//   product         : final result, held until the next accepted start
interface mult_nibble_sequencer_if #(
  parameter int unsigned OP_W = 8
) ();
  logic                start;
  logic [OP_W-1:0]     a_in;
  logic [OP_W-1:0]     b_in;
  logic                ready;
  logic                busy;
  logic [OP_W/2-1:0]   a_nib;
  logic [OP_W/2-1:0]   b_nib;
  logic [1:0]          state;
  logic [2*OP_W-1:0]   pp_in;
  logic [2*OP_W-1:0]   product;
  logic                done;

  modport slave (
    input  start, a_in, b_in, pp_in,
    output ready, busy, a_nib, b_nib, state, product, done
  );

  modport master (
    output start, a_in, b_in, pp_in,
    input  ready, busy, a_nib, b_nib, state, product, done
  );
endinterface

// File: rtl/mult_nibble_sequencer.sv
// Control and accumulate front-end of the nibble multiplier.
// Latches two operands, walks a 2-bit shift code 00..11 presenting one nibble pair per
// step, accumulates the aligned partial products returned on pp_in and publishes the
// product with a one-cycle done pulse.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mult_nibble_sequencer_if.slave (start/a_in/b_in/pp_in in;
//           ready/busy/a_nib/b_nib/state/product/done out)
// Optional feature macro: MULT_ZERO_SKIP_EN -- a zero operand bypasses RUN and goes
// straight to DONE with a zero product.
module mult_nibble_sequencer #(
  parameter int unsigned OP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  mult_nibble_sequencer_if.slave   bus
);

  localparam int unsigned NibW = OP_W / 2;
  localparam int unsigned PW   = 2 * OP_W;

  typedef enum logic [1:0] {StIdle, StRun, StDone} fsm_e;

  fsm_e            fsm_q, fsm_d;
  logic [1:0]      step_q, step_d;
  logic [OP_W-1:0] a_q, a_d;
  logic [OP_W-1:0] b_q, b_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   product_q, product_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q     <= StIdle;
      step_q    <= 2'b00;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      fsm_q     <= fsm_d;
      step_q    <= step_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    step_d    = step_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    product_d = product_q;
    unique case (fsm_q)
      StIdle, StDone: begin
        if (bus.start) begin
          a_d    = bus.a_in;
          b_d    = bus.b_in;
          acc_d  = '0;
          step_d = 2'b00;
          fsm_d  = StRun;
`ifdef MULT_ZERO_SKIP_EN
          if ((bus.a_in == '0) || (bus.b_in == '0)) begin
            // Zeroed operands keep the nibble outputs at 0 while sitting in DONE.
            a_d       = '0;
            b_d       = '0;
            product_d = '0;
            fsm_d     = StDone;
          end
`endif
        end else if (fsm_q == StDone) begin
          fsm_d = StIdle;
        end
      end
      StRun: begin
        acc_d = acc_q + bus.pp_in;
        if (step_q == 2'b11) begin
          // step stays at 11 so DONE keeps presenting the last nibble pair.
          product_d = acc_d;
          fsm_d     = StDone;
        end else begin
          step_d = step_q + 2'd1;
        end
      end
      default: fsm_d = StIdle;
    endcase
  end

  // step bit 0 selects the multiplicand half, bit 1 the multiplier half.
  always_comb begin
    bus.a_nib = '0;
    bus.b_nib = '0;
    bus.state = 2'b00;
    if (fsm_q != StIdle) begin
      bus.a_nib = step_q[0] ? a_q[OP_W-1:NibW] : a_q[NibW-1:0];
      bus.b_nib = step_q[1] ? b_q[OP_W-1:NibW] : b_q[NibW-1:0];
      bus.state = step_q;
    end
  end

  assign bus.ready   = (fsm_q != StRun);
  assign bus.busy    = (fsm_q == StRun);
  assign bus.done    = (fsm_q == StDone);
  assign bus.product = product_q;

endmodule

// File: doc/mult_nibble_sequencer.md
Name: mult_nibble_sequencer

Overview:
- Control and accumulate front-end of the 8-bit nibble multiplier.
- Latches two operands and splits each into low and high nibbles.
- Steps a 2-bit shift state through 00, 01, 10, 11 and presents one nibble pair per step to the 4x4 partial-product path.
- Accumulates the zero-aligned 2*OP_W partial product returned by the alignment stage, then publishes the final product with a done pulse.

Parameters:
- OP_W, 8: operand width. Must be even and ≥ 4. Nibble width is OP_W/2. Product and accumulator width is 2*OP_W.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a multiply; sampled only when ready=1
- a_in  input  OP_W  multiplicand, sampled with accepted start
- b_in  input  OP_W  multiplier, sampled with accepted start
- ready  output  1  block can accept start (IDLE or DONE)
- busy  output  1  sequence in progress (RUN)
- a_nib  output  OP_W/2  selected multiplicand nibble for the current step
- b_nib  output  OP_W/2  selected multiplier nibble for the current step
- state  output  2  shift code for the alignment stage
- pp_in  input  2*OP_W  aligned partial product for the current step; combinational return, same cycle
- product  output  2*OP_W  final result; held until the next accepted start
- done  output  1  one-cycle pulse when product is updated

Behaviour:
- Reset (async, rst_n=0):
  - FSM=IDLE, step=00, acc=0, product=0, done=0, busy=0, ready=1.
  - a_nib=0, b_nib=0, state=00.
  - Internal operand registers cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready=1. On start=1: latch a_in/b_in, clear acc, step<=00, go to RUN.
- RUN (exactly 4 cycles, busy=1, ready=0):
  - state=step.
  - Nibble select:
    - 00: a_lo, b_lo
    - 01: a_hi, b_lo
    - 10: a_lo, b_hi
    - 11: a_hi, b_hi
  - lo = bits [OP_W/2-1:0], hi = bits [OP_W-1:OP_W/2].
  - Each RUN edge: acc <= acc + pp_in, modulo 2^(2*OP_W). No carry-out is kept; a correct unsigned product never overflows.
  - step increments 00→01→10→11.
  - At step 11: product <= acc + pp_in, go to DONE.
- DONE (1 cycle):
  - done=1, ready=1, busy=0.
  - a_nib, b_nib and state hold their step-11 values.
  - If start=1: latch new operands, clear acc, step<=00, go to RUN (back-to-back; done still pulses this cycle). Otherwise go to IDLE.
- Latency:
  - start accepted at edge T.
  - RUN covers cycles T+1..T+4.
  - done=1 and product valid in cycle T+5.
  - Throughput: one multiply per 5 cycles back-to-back.
- start while busy=1: ignored. No queuing; operands are not resampled.
- Operand changes on a_in/b_in during RUN have no effect.
- Reset asserted mid-RUN: immediate return to reset values. product is cleared; no done pulse.
- In IDLE, a_nib/b_nib/state are driven to 0/0/00.
- Arithmetic is unsigned only.

Optional Feature:
- Macro: MULT_ZERO_SKIP_EN.
- Defined: when start is accepted and either a_in==0 or b_in==0, skip RUN.
  - Go directly to DONE with product<=0.
  - done pulses at T+1.
  - busy stays 0.
  - a_nib/b_nib/state stay 0/0/00.
- Undefined: every accepted start runs the full 4-step sequence regardless of operand values. The product is 0 at T+5.

Test Plan:
- Reset, then a=8'hFF, b=8'hFF, start 1 cycle; model pp_in as aligned nibble products.
  - Expected: state 00,01,10,11 on T+1..T+4.
  - Nibbles: (F,F) each step.
  - done only at T+5, product=16'hFE01.
- a=8'h12, b=8'h34.
  - Expected nibbles per step: (2,4), (1,4), (2,3), (1,3).
  - product=16'h03A8.
- Back-to-back: start held high through DONE with a=8'h0A,b=8'h0B then a=8'h10,b=8'h10.
  - Expected: first done with 16'h006E, second RUN begins next cycle.
  - Second done 5 cycles later with 16'h0100.
- start pulsed during RUN with different operands.
  - Expected: ignored, and the original result completes unchanged.
- rst_n low at step 10 of a run.
  - Expected: outputs return to reset values immediately, with no done.
  - A fresh start afterwards yields a correct product.
- a=8'h00, b=8'h5A.
  - Without MULT_ZERO_SKIP_EN: done at T+5, product=0.
  - With it: done at T+1, product=0, busy never asserted.
